regfile_wb_arbiter: RTL and testbench

Write-back arbiter that shares the single write port of Register_Bank (write_enable, write_loc, write_data) between two producers: the ALU result path and the memory load-return path.
- Each producer has a one-entry holding slot behind a valid/ready handshake.
- Occupied slots drain into a registered write port under round-robin arbitration, with an age rule that preserves write order to the same register.
- Exports a pending-write mask so the issue stage can stall on RAW hazards against buffered results.

---
 rtl/regfile_wb_arbiter.sv | 179 +++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: two one-entry producer slots (ALU, memory) share the
// single Register_Bank write port under round-robin plus same-register age ordering.
`timescale 1ns/1ps

module regfile_wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int LOC_W      = 5,
    parameter bit DISCARD_R0 = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [LOC_W-1:0]  alu_loc,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [LOC_W-1:0]  mem_loc,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    output logic              write_enable,
    output logic [LOC_W-1:0]  write_loc,
    output logic [DATA_W-1:0] write_data,
    output logic [31:0]       pending_mask,
    output logic              busy
);

    // Register 0 never appears in the hazard mask when its writes are discarded.
    function automatic logic [31:0] loc_bit(input logic [LOC_W-1:0] loc);
        if (DISCARD_R0 && (loc == {LOC_W{1'b0}})) begin
            loc_bit = 32'd0;
        end else begin
            loc_bit = 32'd1 << loc;
        end
    endfunction

    logic              alu_full_r, mem_full_r;
    logic [LOC_W-1:0]  alu_loc_r, mem_loc_r;
    logic [DATA_W-1:0] alu_data_r, mem_data_r;
    logic              alu_young_r, mem_young_r;
    logic              rr_mem_r;

    logic              grant_alu_s, grant_mem_s, rr_toggle_s;
    logic              alu_older_s, mem_older_s;
    logic              alu_take_s, mem_take_s;
    logic              alu_full_s, mem_full_s, alu_young_s, mem_young_s;
    logic [LOC_W-1:0]  alu_loc_s, mem_loc_s, sel_loc_s, write_loc_s;
    logic [DATA_W-1:0] alu_data_s, mem_data_s, sel_data_s, write_data_s;
    logic              write_enable_s, busy_s;
    logic [31:0]       pending_mask_s;

    // Grant selection: age first, then same-register ordering, then round-robin.
    always_comb begin
        grant_alu_s = 1'b0;
        grant_mem_s = 1'b0;
        rr_toggle_s = 1'b0;
        alu_older_s = mem_young_r && !alu_young_r;
        mem_older_s = alu_young_r && !mem_young_r;
        if (alu_full_r && mem_full_r) begin
            if (alu_older_s) begin
                grant_alu_s = 1'b1;
            end else if (mem_older_s) begin
                grant_mem_s = 1'b1;
            end else if (alu_loc_r == mem_loc_r) begin
                // Same-edge capture to one register: the load is treated as older.
                grant_mem_s = 1'b1;
            end else begin
                rr_toggle_s = 1'b1;
                if (rr_mem_r) begin
                    grant_mem_s = 1'b1;
                end else begin
                    grant_alu_s = 1'b1;
                end
            end
        end else if (alu_full_r) begin
            grant_alu_s = 1'b1;
        end else if (mem_full_r) begin
            grant_mem_s = 1'b1;
        end else begin
            grant_alu_s = 1'b0;
        end
    end

    assign alu_ready  = rst && (!alu_full_r || grant_alu_s);
    assign mem_ready  = rst && (!mem_full_r || grant_mem_s);
    assign alu_take_s = alu_valid && alu_ready;
    assign mem_take_s = mem_valid && mem_ready;

    // Next slot contents, age flags and registered output values.
    always_comb begin
        alu_full_s  = alu_full_r;
        alu_loc_s   = alu_loc_r;
        alu_data_s  = alu_data_r;
        alu_young_s = alu_young_r;
        mem_full_s  = mem_full_r;
        mem_loc_s   = mem_loc_r;
        mem_data_s  = mem_data_r;
        mem_young_s = mem_young_r;
        if (alu_take_s) begin
            alu_full_s  = 1'b1;
            alu_loc_s   = alu_loc;
            alu_data_s  = alu_data;
            // Younger only if the other entry survives this edge.
            alu_young_s = mem_full_r && !grant_mem_s;
        end else if (grant_alu_s) begin
            alu_full_s  = 1'b0;
        end else if (grant_mem_s) begin
            alu_young_s = 1'b0;
        end else begin
            alu_full_s  = alu_full_r;
        end
        if (mem_take_s) begin
            mem_full_s  = 1'b1;
            mem_loc_s   = mem_loc;
            mem_data_s  = mem_data;
            mem_young_s = alu_full_r && !grant_alu_s;
        end else if (grant_mem_s) begin
            mem_full_s  = 1'b0;
        end else if (grant_alu_s) begin
            mem_young_s = 1'b0;
        end else begin
            mem_full_s  = mem_full_r;
        end
        if (grant_mem_s) begin
            sel_loc_s  = mem_loc_r;
            sel_data_s = mem_data_r;
        end else begin
            sel_loc_s  = alu_loc_r;
            sel_data_s = alu_data_r;
        end
        write_enable_s = (grant_alu_s || grant_mem_s) &&
                         !(DISCARD_R0 && (sel_loc_s == {LOC_W{1'b0}}));
        if (write_enable_s) begin
            write_loc_s  = sel_loc_s;
            write_data_s = sel_data_s;
        end else begin
            write_loc_s  = write_loc;
            write_data_s = write_data;
        end
        pending_mask_s = (alu_full_s ? loc_bit(alu_loc_s) : 32'd0) |
                         (mem_full_s ? loc_bit(mem_loc_s) : 32'd0);
        busy_s = alu_full_s || mem_full_s || write_enable_s;
    end

    // State and output registers; reset drops any buffered results.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_full_r   <= 1'b0;
            alu_loc_r    <= {LOC_W{1'b0}};
            alu_data_r   <= {DATA_W{1'b0}};
            alu_young_r  <= 1'b0;
            mem_full_r   <= 1'b0;
            mem_loc_r    <= {LOC_W{1'b0}};
            mem_data_r   <= {DATA_W{1'b0}};
            mem_young_r  <= 1'b0;
            rr_mem_r     <= 1'b0;
            write_enable <= 1'b0;
            write_loc    <= {LOC_W{1'b0}};
            write_data   <= {DATA_W{1'b0}};
            pending_mask <= 32'd0;
            busy         <= 1'b0;
        end else begin
            alu_full_r   <= alu_full_s;
            alu_loc_r    <= alu_loc_s;
            alu_data_r   <= alu_data_s;
            alu_young_r  <= alu_young_s;
            mem_full_r   <= mem_full_s;
            mem_loc_r    <= mem_loc_s;
            mem_data_r   <= mem_data_s;
            mem_young_r  <= mem_young_s;
            rr_mem_r     <= rr_toggle_s ? !rr_mem_r : rr_mem_r;
            write_enable <= write_enable_s;
            write_loc    <= write_loc_s;
            write_data   <= write_data_s;
            pending_mask <= pending_mask_s;
            busy         <= busy_s;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: expected writes are queued in the
// order the arbitration rules dictate and popped as the write port fires.
`timescale 1ns/1ps

module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alu_valid = 1'b0, mem_valid = 1'b0;
    logic [4:0]  alu_loc = 5'd0, mem_loc = 5'd0;
    logic [31:0] alu_data = 32'd0, mem_data = 32'd0;
    logic        alu_ready, mem_ready, write_enable, busy;
    logic [4:0]  write_loc;
    logic [31:0] write_data, pending_mask;

    typedef struct packed { logic [4:0] loc; logic [31:0] data; } wr_t;
    wr_t         exp_q[$];
    logic [31:0] rf_model [32];
    int          checks = 0;
    int          failures = 0;

    regfile_wb_arbiter #(.DATA_W(32), .LOC_W(5), .DISCARD_R0(1'b1)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_loc(alu_loc), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_loc(mem_loc), .mem_data(mem_data), .mem_ready(mem_ready),
        .write_enable(write_enable), .write_loc(write_loc), .write_data(write_data),
        .pending_mask(pending_mask), .busy(busy)
    );

    always #5 clk = ~clk;

    // Write-port monitor: every write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst && write_enable) begin
            wr_t e;
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_write: got loc=%0d data=%h, expected no write", write_loc, write_data);
                failures++;
            end else begin
                e = exp_q.pop_front();
                if (write_loc !== e.loc || write_data !== e.data) begin
                    $display("FAIL write_order: got loc=%0d data=%h, expected loc=%0d data=%h",
                             write_loc, write_data, e.loc, e.data);
                    failures++;
                end
            end
            rf_model[write_loc] = write_data;
        end
    end

    task automatic alu_send(input logic [4:0] loc, input logic [31:0] data);
        int n = 0;
        alu_valid = 1'b1; alu_loc = loc; alu_data = data;
        while (!alu_ready && n < 50) begin @(posedge clk); #1; n++; end
        checks++;
        if (n >= 50) begin $display("FAIL alu_handshake: ready never rose, expected ready within 50 cycles"); failures++; end
        @(posedge clk); #1;
        alu_valid = 1'b0;
    endtask

    task automatic mem_send(input logic [4:0] loc, input logic [31:0] data);
        int n = 0;
        mem_valid = 1'b1; mem_loc = loc; mem_data = data;
        while (!mem_ready && n < 50) begin @(posedge clk); #1; n++; end
        checks++;
        if (n >= 50) begin $display("FAIL mem_handshake: ready never rose, expected ready within 50 cycles"); failures++; end
        @(posedge clk); #1;
        mem_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (n >= 100) begin
            $display("FAIL %s_drain: %0d writes outstanding busy=%b, expected 0 and busy=0", name, exp_q.size(), busy);
            failures++;
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({write_enable, write_loc, write_data, pending_mask, busy, alu_ready, mem_ready} !== 72'd0) begin
            $display("FAIL reset_outputs: we=%b loc=%0d data=%h mask=%h busy=%b rdy=%b%b, expected all 0",
                     write_enable, write_loc, write_data, pending_mask, busy, alu_ready, mem_ready);
            failures++;
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin
            $display("FAIL ready_after_reset: alu=%b mem=%b, expected 1 1", alu_ready, mem_ready);
            failures++;
        end
        @(negedge clk);
        alu_valid = 1'b1; alu_loc = 5'd3; alu_data = 32'h33;
        mem_valid = 1'b1; mem_loc = 5'd4; mem_data = 32'h44;
        @(posedge clk); #1;
        alu_valid = 1'b0; mem_valid = 1'b0;
        checks++;
        if (pending_mask !== 32'h18 || busy !== 1'b1) begin
            $display("FAIL slots_full: mask=%h busy=%b, expected 00000018 1", pending_mask, busy);
            failures++;
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (write_enable !== 1'b0 || pending_mask !== 32'd0 || busy !== 1'b0 || alu_ready !== 1'b0) begin
            $display("FAIL async_reset: we=%b mask=%h busy=%b rdy=%b, expected 0 0 0 0",
                     write_enable, pending_mask, busy, alu_ready);
            failures++;
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (alu_ready !== 1'b1 || mem_ready !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL post_reset_idle: rdy=%b%b busy=%b, expected 11 0", alu_ready, mem_ready, busy);
            failures++;
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        alu_valid = 1'b1; alu_loc = 5'd28; alu_data = 32'd143434;
        exp_q.push_back('{loc: 5'd28, data: 32'd143434});
        @(posedge clk); #1;
        alu_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (pending_mask !== 32'h1000_0000 || write_enable !== 1'b0) begin
            $display("FAIL single_pending: mask=%h we=%b, expected 10000000 0", pending_mask, write_enable);
            failures++;
        end
        @(negedge clk);
        checks++;
        if (write_enable !== 1'b1 || pending_mask !== 32'd0) begin
            $display("FAIL single_write: we=%b mask=%h, expected 1 00000000", write_enable, pending_mask);
            failures++;
        end
        @(negedge clk);
        checks++;
        if (write_enable !== 1'b0 || write_loc !== 5'd28 || write_data !== 32'd143434) begin
            $display("FAIL single_hold: we=%b loc=%0d data=%0d, expected 0 28 143434", write_enable, write_loc, write_data);
            failures++;
        end
        wait_drain("single");
    endtask

    task automatic test_stream();
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back('{loc: 5'd30, data: 32'd1 + 32'(2 * k)});
            exp_q.push_back('{loc: 5'd28, data: 32'd2 + 32'(2 * k)});
        end
        @(negedge clk);
        fork
            for (int k = 0; k < 3; k++) alu_send(5'd30, 32'd1 + 32'(2 * k));
            for (int k = 0; k < 3; k++) mem_send(5'd28, 32'd2 + 32'(2 * k));
        join
        wait_drain("stream");
    endtask

    task automatic test_same_loc();
        @(negedge clk);
        alu_valid = 1'b1; alu_loc = 5'd30; alu_data = 32'h5555;
        mem_valid = 1'b1; mem_loc = 5'd30; mem_data = 32'hAAAA;
        exp_q.push_back('{loc: 5'd30, data: 32'hAAAA});
        exp_q.push_back('{loc: 5'd30, data: 32'h5555});
        @(posedge clk); #1;
        alu_valid = 1'b0; mem_valid = 1'b0;
        wait_drain("same_loc");
        checks++;
        if (rf_model[30] !== 32'h5555) begin
            $display("FAIL same_loc_final: loc30=%h, expected 00005555", rf_model[30]);
            failures++;
        end
    endtask

    task automatic test_age();
        // rr points at mem here, so mem 7 wins first; then mem 5 becomes younger
        // than ALU 9, and ALU 5 arrives while mem 5 is still waiting.
        exp_q.push_back('{loc: 5'd7, data: 32'h77});
        exp_q.push_back('{loc: 5'd9, data: 32'h99});
        exp_q.push_back('{loc: 5'd5, data: 32'hBBBB});
        exp_q.push_back('{loc: 5'd5, data: 32'hCCCC});
        @(negedge clk);
        fork
            begin alu_send(5'd9, 32'h99); alu_send(5'd5, 32'hCCCC); end
            begin mem_send(5'd7, 32'h77); mem_send(5'd5, 32'hBBBB); end
        join
        wait_drain("age");
        checks++;
        if (rf_model[5] !== 32'hCCCC) begin
            $display("FAIL age_final: loc5=%h, expected 0000cccc", rf_model[5]);
            failures++;
        end
    endtask

    task automatic test_discard_r0();
        @(negedge clk);
        alu_valid = 1'b1; alu_loc = 5'd0; alu_data = 32'd7;
        checks++;
        if (alu_ready !== 1'b1) begin
            $display("FAIL r0_ready: got %b, expected 1", alu_ready);
            failures++;
        end
        @(posedge clk); #1;
        alu_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (pending_mask !== 32'd0 || busy !== 1'b1 || write_enable !== 1'b0) begin
            $display("FAIL r0_captured: mask=%h busy=%b we=%b, expected 0 1 0", pending_mask, busy, write_enable);
            failures++;
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || write_enable !== 1'b0 || pending_mask !== 32'd0) begin
            $display("FAIL r0_drop: busy=%b we=%b mask=%h, expected 0 0 0", busy, write_enable, pending_mask);
            failures++;
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf_model[i] = 32'd0;
        test_reset();
        test_single();
        test_stream();
        test_same_loc();
        test_age();
        test_discard_r0();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL scoreboard_empty: %0d left, expected 0", exp_q.size());
            failures++;
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
